ntt_cdma_sequencer: RTL
=======================

NTT_CDMA_SEQUENCER -- requirements
Module: ntt_cdma_sequencer

Interface
REQ-001 SHALL have parameter C_CDMA_BASE, default 32'h7E20_0000, CDMA register base (CR +0x00, SR +0x04, SA +0x18, DA +0x20, BTT +0x28).
REQ-002 SHALL have parameter C_NTT_CTRL_BASE, default 32'h43C0_0000, NTT control register address.
REQ-003 SHALL have parameter C_NTT_DATA_BASE, default 32'h7600_0000, NTT BRAM address used as CDMA target/source.
REQ-004 SHALL have parameter C_BTT, default 512, bytes per transfer (256 x 16-bit).
REQ-005 SHALL have parameter C_TIMEOUT_CYCLES, default 65535, IRQ wait limit.
REQ-006 SHALL have the following ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job request.
- mode  in  1  0=NTT, 1=iNTT.
- ddr_addr  in  32  DDR buffer address.
- cdma_irq  in  1  CDMA IOC interrupt, level.
- ntt_irq  in  1  NTT done interrupt, level.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky error flag.
- m_awaddr/m_awvalid/m_awready  out/out/in  32/1/1  AXI-Lite write address.
- m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  32/4/1/1  AXI-Lite write data.
- m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  AXI-Lite write response.
- m_araddr/m_arvalid/m_arready  out/out/in  32/1/1  AXI-Lite read address.
- m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  32/2/1/1  AXI-Lite read data.

Function
REQ-007 SHALL sample mode and ddr_addr on accepted start and hold them for the job; start SHALL be accepted only in IDLE and ignored otherwise.
REQ-008 SHALL sequence the states IDLE -> INIT_CR -> LD_SA -> LD_DA -> LD_BTT -> LD_WAIT -> LD_SR -> LD_CLR -> NTT_GO -> NTT_REL -> NTT_WAIT -> NTT_ACK -> ST_SA -> ST_DA -> ST_BTT -> ST_WAIT -> ST_SR -> ST_CLR -> DONE -> IDLE.
REQ-009 SHALL perform these writes: INIT_CR writes CR = 0x0000_1000; LD_SA/LD_DA write SA = ddr_addr, DA = C_NTT_DATA_BASE; ST_SA/ST_DA write SA = C_NTT_DATA_BASE, DA = ddr_addr; LD_BTT/ST_BTT write BTT = C_BTT; *_CLR writes SR = 0x0000_F000; NTT_GO writes {30'b0, mode, 1'b1}; NTT_REL and NTT_ACK write 0.
REQ-010 SHALL perform each write as follows: assert AWVALID and WVALID together with WSTRB = 4'hF; drop each valid independently on its handshake; hold BREADY high; advance only on BVALID.
REQ-011 SHALL have at most one AXI transaction outstanding; address and data SHALL be stable while valid is high.
REQ-012 SHALL perform each read (LD_SR, ST_SR) of CDMA SR as: assert ARVALID until ARREADY, with RREADY high; then on RVALID, go to ERR if RDATA[13] = 1, else advance.
REQ-013 SHALL go to ERR on any BRESP or RRESP not equal to 2'b00, after the response is consumed.
REQ-014 SHALL have *_WAIT states that advance on the first cycle the relevant IRQ is high (cdma_irq for LD/ST, ntt_irq for NTT); an IRQ that is already high on entry SHALL be accepted immediately.
REQ-015 SHALL have DONE last one cycle: done = 1, then IDLE; busy = 1 in every state except IDLE and ERR.
REQ-016 SHALL on entering ERR set error = 1 and done = 0, and SHALL return to IDLE one cycle later with error remaining set; the next accepted start SHALL clear error.
REQ-017 SHALL issue INIT_CR only on the first job after reset; later jobs SHALL start at LD_SA.

Reset
REQ-018 SHALL on ARESETn low immediately force IDLE, busy = 0, done = 0, error = 0, all valids = 0, BREADY = RREADY = 0, and SHALL clear the INIT_CR-done flag.
REQ-019 SHALL abandon any in-flight transaction on mid-job reset, without completing it.

Configuration
REQ-020 SHALL when SEQ_TIMEOUT_EN is defined run a counter in each *_WAIT state, cleared on entry; reaching C_TIMEOUT_CYCLES without the IRQ SHALL go to ERR.
REQ-021 SHALL when SEQ_TIMEOUT_EN is undefined have no counter, with *_WAIT states waiting indefinitely.

Verification
REQ-022 SHALL pass: start, mode=0, ddr_addr=0x0A00_0000, slave always ready, IRQs 10 cycles after each trigger -> write sequence CR=0x1000, SA=0x0A00_0000, DA=0x7600_0000, BTT=512, SR=0xF000, CTRL=1, CTRL=0, CTRL=0, SA=0x7600_0000, DA=0x0A00_0000, BTT=512, SR=0xF000, then a one-cycle done.
REQ-023 SHALL pass: a second job with mode=1 -> no CR write, NTT_GO data = 0x3, done asserted.
REQ-024 SHALL pass: SR read returns 0x0000_2000 in LD_SR -> no NTT write issued, error=1, busy=0.
REQ-025 SHALL pass: BRESP=2'b10 on LD_DA -> ERR, error=1; a following start clears error and the job completes.
REQ-026 SHALL pass: AWREADY delayed 5 cycles, WREADY delayed 2 cycles -> AWADDR/WDATA stable throughout, exactly one write counted.
REQ-027 SHALL pass: with SEQ_TIMEOUT_EN and C_TIMEOUT_CYCLES=100, ntt_irq never asserts -> error=1 after 100 cycles in NTT_WAIT; ARESETn pulsed mid-job -> all outputs zero at once.

Source files
------------

// File: rtl/ntt_cdma_sequencer.sv
// Drives an AXI CDMA and an NTT core over AXI-Lite: DDR->BRAM load, NTT run, BRAM->DDR store.
// Optional SEQ_TIMEOUT_EN adds a bounded wait on each IRQ.
module ntt_cdma_sequencer #(
  parameter logic [31:0] C_CDMA_BASE      = 32'h7E20_0000,
  parameter logic [31:0] C_NTT_CTRL_BASE  = 32'h43C0_0000,
  parameter logic [31:0] C_NTT_DATA_BASE  = 32'h7600_0000,
  parameter int unsigned C_BTT            = 512,
  parameter int unsigned C_TIMEOUT_CYCLES = 65535
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] ddr_addr,
  input  logic        cdma_irq,
  input  logic        ntt_irq,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  typedef enum logic [4:0] {
    IDLE, INIT_CR, LD_SA, LD_DA, LD_BTT, LD_WAIT, LD_SR, LD_CLR,
    NTT_GO, NTT_REL, NTT_WAIT, NTT_ACK, ST_SA, ST_DA, ST_BTT, ST_WAIT,
    ST_SR, ST_CLR, DONE, ERR
  } state_t;

  state_t      state, nxt;
  logic        init_done, txn, mode_q;
  logic [31:0] ddr_q;
  logic        is_wr, is_rd, is_wait, irq_sel, to_hit;

  function automatic state_t succ(input state_t s);
    case (s)
      INIT_CR:  return LD_SA;
      LD_SA:    return LD_DA;
      LD_DA:    return LD_BTT;
      LD_BTT:   return LD_WAIT;
      LD_WAIT:  return LD_SR;
      LD_SR:    return LD_CLR;
      LD_CLR:   return NTT_GO;
      NTT_GO:   return NTT_REL;
      NTT_REL:  return NTT_WAIT;
      NTT_WAIT: return NTT_ACK;
      NTT_ACK:  return ST_SA;
      ST_SA:    return ST_DA;
      ST_DA:    return ST_BTT;
      ST_BTT:   return ST_WAIT;
      ST_WAIT:  return ST_SR;
      ST_SR:    return ST_CLR;
      ST_CLR:   return DONE;
      default:  return IDLE;
    endcase
  endfunction

  assign is_wr = state inside {INIT_CR, LD_SA, LD_DA, LD_BTT, LD_CLR, NTT_GO, NTT_REL,
                               NTT_ACK, ST_SA, ST_DA, ST_BTT, ST_CLR};
  assign is_rd   = state inside {LD_SR, ST_SR};
  assign is_wait = state inside {LD_WAIT, NTT_WAIT, ST_WAIT};
  assign irq_sel = (state == NTT_WAIT) ? ntt_irq : cdma_irq;

  assign busy     = (state != IDLE) && (state != ERR);
  assign done     = (state == DONE);
  assign m_wstrb  = 4'hF;
  assign m_bready = is_wr;
  assign m_rready = is_rd;
  assign m_araddr = C_CDMA_BASE + 32'h04;

  // Address and data are pure functions of the state and the latched job, so they hold while valid is up
  always_comb begin
    m_awaddr = C_CDMA_BASE;
    m_wdata  = '0;
    case (state)
      INIT_CR:          m_wdata = 32'h0000_1000;
      LD_SA:            begin m_awaddr = C_CDMA_BASE + 32'h18; m_wdata = ddr_q;           end
      LD_DA:            begin m_awaddr = C_CDMA_BASE + 32'h20; m_wdata = C_NTT_DATA_BASE; end
      ST_SA:            begin m_awaddr = C_CDMA_BASE + 32'h18; m_wdata = C_NTT_DATA_BASE; end
      ST_DA:            begin m_awaddr = C_CDMA_BASE + 32'h20; m_wdata = ddr_q;           end
      LD_BTT, ST_BTT:   begin m_awaddr = C_CDMA_BASE + 32'h28; m_wdata = 32'(C_BTT);      end
      LD_CLR, ST_CLR:   begin m_awaddr = C_CDMA_BASE + 32'h04; m_wdata = 32'h0000_F000;   end
      NTT_GO:           begin m_awaddr = C_NTT_CTRL_BASE; m_wdata = {30'b0, mode_q, 1'b1}; end
      NTT_REL, NTT_ACK: m_awaddr = C_NTT_CTRL_BASE;
      default: ;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (start) nxt = init_done ? LD_SA : INIT_CR;
      DONE, ERR: nxt = IDLE;
      default: begin
        if (is_wr && txn && m_bvalid)
          nxt = (m_bresp != 2'b00) ? ERR : succ(state);
        else if (is_rd && txn && m_rvalid)
          nxt = (m_rresp != 2'b00 || m_rdata[13]) ? ERR : succ(state);
        else if (is_wait)
          nxt = irq_sel ? succ(state) : (to_hit ? ERR : state);
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= nxt;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      init_done <= 1'b0;
      txn       <= 1'b0;
      mode_q    <= 1'b0;
      ddr_q     <= '0;
      error     <= 1'b0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_arvalid <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        mode_q <= mode;
        ddr_q  <= ddr_addr;
        error  <= 1'b0;
      end
      if (nxt == ERR) error <= 1'b1;
      if (state == INIT_CR && nxt == LD_SA) init_done <= 1'b1;
      if (nxt != state) begin
        txn       <= 1'b0;
        m_awvalid <= 1'b0;
        m_wvalid  <= 1'b0;
        m_arvalid <= 1'b0;
      end else if ((is_wr || is_rd) && !txn) begin
        txn       <= 1'b1;
        m_awvalid <= is_wr;
        m_wvalid  <= is_wr;
        m_arvalid <= is_rd;
      end else begin
        if (m_awvalid && m_awready) m_awvalid <= 1'b0;
        if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
        if (m_arvalid && m_arready) m_arvalid <= 1'b0;
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] wait_cnt;
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                     wait_cnt <= '0;
    else if (!is_wait || nxt != state) wait_cnt <= '0;
    else                              wait_cnt <= wait_cnt + 32'd1;
  end
  assign to_hit = (wait_cnt == C_TIMEOUT_CYCLES - 1);
  logic unused_ok;
  assign unused_ok = ^{m_rdata[31:14], m_rdata[12:0]};
`else
  assign to_hit = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{m_rdata[31:14], m_rdata[12:0], (C_TIMEOUT_CYCLES != 0)};
`endif

endmodule
